// File: rtl/sl_bridge_pkg.sv
// ----------------------------------------------------------------------------
// sl_bridge_pkg: shared widths, word modifiers and scheduler state encoding. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
package sl_bridge_pkg;

  localparam int FIFO_W = 34;
  localparam int CFG_W  = 16;
  localparam int STAT_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    MOD_CONFIG  = 2'd0,
    MOD_DATA    = 2'd1,
    MOD_STATUS  = 2'd2,
    MOD_CHANNEL = 2'd3
  } mod_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_CHAN = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_STAT = 3'd3,
    ST_WR_CFG  = 3'd4,
    ST_ACK     = 3'd5
  } state_t;

  function automatic logic [FIFO_W-1:0] make_word(input mod_t mod, input logic [DATA_W-1:0] payload);
    return {mod, payload};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sl_report_scheduler_if.sv
// ----------------------------------------------------------------------------
// sl_report_scheduler_if: channel request/register side plus outbound FIFO write port. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
interface sl_report_scheduler_if #(parameter int CH_COUNT = 4);
  import sl_bridge_pkg::*;

  logic [CH_COUNT-1:0]        req_cfg;
  logic [CH_COUNT-1:0]        req_dat;
  logic [CFG_W*CH_COUNT-1:0]  cfg_flat;
  logic [STAT_W*CH_COUNT-1:0] stat_flat;
  logic [DATA_W*CH_COUNT-1:0] data_flat;
  logic                       fifo_write_full;
  logic [FIFO_W-1:0]          fifo_write_data;
  logic                       fifo_write_inc;
  logic [CH_COUNT-1:0]        ack;
  logic                       ack_is_cfg;
  logic                       busy;

  modport master (
    output req_cfg, req_dat, cfg_flat, stat_flat, data_flat, fifo_write_full,
    input  fifo_write_data, fifo_write_inc, ack, ack_is_cfg, busy
  );

  modport slave (
    input  req_cfg, req_dat, cfg_flat, stat_flat, data_flat, fifo_write_full,
    output fifo_write_data, fifo_write_inc, ack, ack_is_cfg, busy
  );

endinterface
`default_nettype wire

// File: rtl/sl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// sl_rr_arbiter: combinational round-robin pick, first request after i_ptr with wrap. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module sl_rr_arbiter #(
  parameter int CH_COUNT = 4,
  localparam int CH_W    = $clog2(CH_COUNT)
) (
  input  wire logic [CH_COUNT-1:0] i_req,
  input  wire logic [CH_W-1:0]     i_ptr,
  output logic      [CH_COUNT-1:0] o_grant,
  output logic      [CH_W-1:0]     o_grant_idx,
  output logic                     o_any
);

  always_comb begin
    int idx;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    idx         = 0;
    // Offset CH_COUNT lands back on i_ptr, so the last owner is considered last.
    for (int k = 1; k <= CH_COUNT; k++) begin
      idx = (int'(i_ptr) + k) % CH_COUNT;
      if (!o_any && i_req[idx]) begin
        o_any        = 1'b1;
        o_grant[idx] = 1'b1;
        o_grant_idx  = CH_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sl_report_scheduler.sv
// ----------------------------------------------------------------------------
// sl_report_scheduler: serialises per-channel change events into tagged FIFO words. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module sl_report_scheduler
  import sl_bridge_pkg::*;
#(
  parameter int CH_COUNT = 4
) (
  input wire logic             clk,
  input wire logic             rst,
  sl_report_scheduler_if.slave bus
);

  localparam int CH_W = $clog2(CH_COUNT);

  state_t              r_state;
  logic [CH_W-1:0]     r_ptr;
  logic [CH_W-1:0]     r_g;
  logic [CH_W-1:0]     r_last_ch;
  logic                r_last_valid;
  logic                r_kind_cfg;
  logic [CFG_W-1:0]    r_cfg;
  logic [STAT_W-1:0]   r_stat;
  logic [DATA_W-1:0]   r_data;
  logic [FIFO_W-1:0]   r_wr_data;
  logic                r_wr_inc;
  logic [CH_COUNT-1:0] r_ack;
  logic                r_ack_is_cfg;

  logic [CH_COUNT-1:0] w_pending;
  logic [CH_COUNT-1:0] w_grant;
  logic [CH_W-1:0]     w_grant_idx;
  logic                w_any;
  logic                w_is_cfg;

  // A channel being acked still shows its request this cycle; hide it.
  assign w_pending = (bus.req_cfg | bus.req_dat) & ~r_ack;
  assign w_is_cfg  = ~|(w_grant & bus.req_dat);

  sl_rr_arbiter #(.CH_COUNT(CH_COUNT)) u_arb (
    .i_req       (w_pending),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= CH_W'(CH_COUNT - 1);
      r_g          <= '0;
      r_last_ch    <= '0;
      r_last_valid <= 1'b0;
      r_kind_cfg   <= 1'b0;
      r_cfg        <= '0;
      r_stat       <= '0;
      r_data       <= '0;
      r_wr_data    <= '0;
      r_wr_inc     <= 1'b0;
      r_ack        <= '0;
      r_ack_is_cfg <= 1'b0;
    end else begin
      r_wr_inc     <= 1'b0;
      r_ack        <= '0;
      r_ack_is_cfg <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_g        <= w_grant_idx;
            r_cfg      <= bus.cfg_flat[CFG_W*w_grant_idx +: CFG_W];
            r_stat     <= bus.stat_flat[STAT_W*w_grant_idx +: STAT_W];
            r_data     <= bus.data_flat[DATA_W*w_grant_idx +: DATA_W];
            r_kind_cfg <= w_is_cfg;
            if (!r_last_valid || (w_grant_idx != r_last_ch)) r_state <= ST_WR_CHAN;
            else r_state <= w_is_cfg ? ST_WR_CFG : ST_WR_DATA;
          end
        end
        ST_WR_CHAN: begin
          if (!bus.fifo_write_full) begin
            r_wr_inc     <= 1'b1;
            r_wr_data    <= make_word(MOD_CHANNEL, {{(DATA_W-CH_W){1'b0}}, r_g});
            r_last_ch    <= r_g;
            r_last_valid <= 1'b1;
            r_state      <= r_kind_cfg ? ST_WR_CFG : ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (!bus.fifo_write_full) begin
            r_wr_inc  <= 1'b1;
            r_wr_data <= make_word(MOD_DATA, r_data);
            r_state   <= ST_WR_STAT;
          end
        end
        ST_WR_STAT: begin
          if (!bus.fifo_write_full) begin
            r_wr_inc  <= 1'b1;
            r_wr_data <= make_word(MOD_STATUS, {{(DATA_W-STAT_W){1'b0}}, r_stat});
            r_state   <= ST_ACK;
          end
        end
        ST_WR_CFG: begin
          if (!bus.fifo_write_full) begin
            r_wr_inc  <= 1'b1;
            r_wr_data <= make_word(MOD_CONFIG, {{(DATA_W-CFG_W){1'b0}}, r_cfg});
            r_state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_ack[r_g]   <= 1'b1;
          r_ack_is_cfg <= r_kind_cfg;
          r_ptr        <= r_g;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.fifo_write_data = r_wr_data;
  assign bus.fifo_write_inc  = r_wr_inc;
  assign bus.ack             = r_ack;
  assign bus.ack_is_cfg      = r_ack_is_cfg;
  assign bus.busy            = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sl_report_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sl_report_scheduler: directed and randomized event batches against a transaction-level model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module tb_sl_report_scheduler;
  import sl_bridge_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sl_report_scheduler_if #(.CH_COUNT(N)) bus ();
  sl_report_scheduler #(.CH_COUNT(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] cfg_r  [N];
  logic [15:0] stat_r [N];
  logic [31:0] data_r [N];

  // Event log entries: writes are {6'h00, word}, acks set bit 39, bit 4 = is_cfg, bit ch = channel.
  logic [39:0] log_q [$];
  logic [39:0] exp_q [$];

  int m_ptr;
  int m_last;
  bit m_lv;

  function automatic logic [39:0] ev_word(input logic [1:0] mod, input logic [31:0] pl);
    return {6'h00, mod, pl};
  endfunction

  function automatic logic [39:0] ev_ack(input int ch, input bit is_cfg);
    logic [39:0] e;
    e     = '0;
    e[39] = 1'b1;
    e[4]  = is_cfg;
    e[ch] = 1'b1;
    return e;
  endfunction

  task automatic drive_regs();
    for (int i = 0; i < N; i++) begin
      bus.cfg_flat[16*i +: 16]  = cfg_r[i];
      bus.stat_flat[16*i +: 16] = stat_r[i];
      bus.data_flat[32*i +: 32] = data_r[i];
    end
  endtask

  task automatic rand_regs();
    for (int i = 0; i < N; i++) begin
      cfg_r[i]  = 16'($urandom);
      stat_r[i] = 16'($urandom);
      data_r[i] = $urandom;
    end
    drive_regs();
  endtask

  // Reference: round-robin over outstanding events; data before config on a channel.
  task automatic model_batch(input logic [N-1:0] pc_in, input logic [N-1:0] pd_in);
    logic [N-1:0] pc;
    logic [N-1:0] pd;
    int ch;
    pc = pc_in;
    pd = pd_in;
    while ((pc | pd) != 0) begin
      ch = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (ch < 0 && (pc[c] || pd[c])) ch = c;
      end
      if (!m_lv || ch != m_last) exp_q.push_back(ev_word(MOD_CHANNEL, 32'(ch)));
      m_last = ch;
      m_lv   = 1'b1;
      m_ptr  = ch;
      if (pd[ch]) begin
        exp_q.push_back(ev_word(MOD_DATA, data_r[ch]));
        exp_q.push_back(ev_word(MOD_STATUS, {16'h0, stat_r[ch]}));
        exp_q.push_back(ev_ack(ch, 1'b0));
        pd[ch] = 1'b0;
      end else begin
        exp_q.push_back(ev_word(MOD_CONFIG, {16'h0, cfg_r[ch]}));
        exp_q.push_back(ev_ack(ch, 1'b1));
        pc[ch] = 1'b0;
      end
    end
  endtask

  // Acts as the requesters: logs words and acks, drops a request the cycle after its ack.
  task automatic collect(input bit rand_full);
    int cyc;
    bit done;
    logic [N-1:0] clr_c;
    logic [N-1:0] clr_d;
    cyc   = 0;
    done  = 1'b0;
    clr_c = '0;
    clr_d = '0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.req_cfg = bus.req_cfg & ~clr_c;
      bus.req_dat = bus.req_dat & ~clr_d;
      clr_c = '0;
      clr_d = '0;
      if (bus.fifo_write_inc) log_q.push_back({6'h00, bus.fifo_write_data});
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i]) begin
          log_q.push_back(ev_ack(i, bus.ack_is_cfg));
          if (bus.ack_is_cfg) clr_c[i] = 1'b1;
          else clr_d[i] = 1'b1;
        end
      end
      bus.fifo_write_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (bus.req_cfg == 0 && bus.req_dat == 0 && !bus.busy && clr_c == 0 && clr_d == 0) done = 1'b1;
    end
    bus.fifo_write_full = 1'b0;
    n_checks++;
    if (!done) $display("FAIL collect_timeout: still busy after %0d cycles, required idle", cyc);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_dat = '1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.fifo_write_inc !== 1'b0) $display("FAIL reset_inc got %b want 0", bus.fifo_write_inc); else n_pass++;
    n_checks++; if (bus.fifo_write_data !== 34'h0) $display("FAIL reset_data got %h want 0", bus.fifo_write_data); else n_pass++;
    n_checks++; if (bus.ack !== 4'h0) $display("FAIL reset_ack got %h want 0", bus.ack); else n_pass++;
    n_checks++; if (bus.ack_is_cfg !== 1'b0) $display("FAIL reset_ack_is_cfg got %b want 0", bus.ack_is_cfg); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    bus.req_dat = '0;
    rst = 1'b0;
    m_ptr = N - 1;
    m_lv  = 1'b0;
    m_last = 0;
  endtask

  task automatic test_first_data();
    log_q.delete(); exp_q.delete();
    data_r[2] = 32'hCAFE0001;
    stat_r[2] = 16'h0005;
    drive_regs();
    exp_q.push_back({6'h00, 34'h3_00000002});
    exp_q.push_back({6'h00, 34'h1_CAFE0001});
    exp_q.push_back({6'h00, 34'h2_00000005});
    exp_q.push_back(ev_ack(2, 1'b0));
    bus.req_dat[2] = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.fifo_write_inc !== 1'b0) $display("FAIL latency_grant_inc got %b want 0", bus.fifo_write_inc); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.fifo_write_inc !== 1'b1) $display("FAIL latency_write_inc got %b want 1", bus.fifo_write_inc); else n_pass++;
    if (bus.fifo_write_inc) log_q.push_back({6'h00, bus.fifo_write_data});
    collect(1'b0);
    n_checks++;
    if (log_q.size() !== exp_q.size()) $display("FAIL first_count got %0d want %0d", log_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_q[i]) $display("FAIL first_event[%0d] got %h want %h", i, log_q[i], exp_q[i]); else n_pass++;
    end
    m_ptr = 2; m_last = 2; m_lv = 1'b1;
  endtask

  task automatic test_cfg_same_channel();
    log_q.delete(); exp_q.delete();
    cfg_r[2] = 16'h00A5;
    drive_regs();
    exp_q.push_back({6'h00, 34'h0_000000A5});
    exp_q.push_back(ev_ack(2, 1'b1));
    bus.req_cfg[2] = 1'b1;
    collect(1'b0);
    n_checks++;
    if (log_q.size() !== exp_q.size()) $display("FAIL samech_count got %0d want %0d", log_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_q[i]) $display("FAIL samech_event[%0d] got %h want %h", i, log_q[i], exp_q[i]); else n_pass++;
    end
    m_ptr = 2;
  endtask

  task automatic test_rr_order();
    log_q.delete(); exp_q.delete();
    rand_regs();
    model_batch(4'b1011, 4'b0000);
    n_checks++;
    if (exp_q[0] !== ev_word(MOD_CHANNEL, 32'd3)) $display("FAIL rr_model_first got %h want channel 3", exp_q[0]); else n_pass++;
    bus.req_cfg = 4'b1011;
    collect(1'b0);
    n_checks++;
    if (log_q.size() !== exp_q.size()) $display("FAIL rr_count got %0d want %0d", log_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_q[i]) $display("FAIL rr_event[%0d] got %h want %h", i, log_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int ch;
    log_q.delete(); exp_q.delete();
    rand_regs();
    ch = (m_last + 2) % N;
    model_batch('0, 4'(1 << ch));
    bus.req_dat[ch] = 1'b1;
    repeat (2) @(negedge clk);
    if (bus.fifo_write_inc) log_q.push_back({6'h00, bus.fifo_write_data});
    bus.fifo_write_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.fifo_write_inc !== 1'b0) $display("FAIL full_hold_inc[%0d] got %b want 0", k, bus.fifo_write_inc); else n_pass++;
    end
    bus.fifo_write_full = 1'b0;
    collect(1'b0);
    n_checks++;
    if (log_q.size() !== exp_q.size()) $display("FAIL full_count got %0d want %0d", log_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_q[i]) $display("FAIL full_event[%0d] got %h want %h", i, log_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_snapshot();
    int ch;
    log_q.delete(); exp_q.delete();
    rand_regs();
    ch = (m_last + 1) % N;
    model_batch('0, 4'(1 << ch));
    bus.req_dat[ch] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL snap_busy got %b want 1", bus.busy); else n_pass++;
    bus.data_flat[32*ch +: 32] = ~data_r[ch];
    bus.stat_flat[16*ch +: 16] = ~stat_r[ch];
    collect(1'b0);
    n_checks++;
    if (log_q.size() !== exp_q.size()) $display("FAIL snap_count got %0d want %0d", log_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_q[i]) $display("FAIL snap_event[%0d] got %h want %h", i, log_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int ch;
    log_q.delete(); exp_q.delete();
    rand_regs();
    ch = m_last;
    bus.req_dat[ch] = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.fifo_write_inc !== 1'b1 || bus.fifo_write_data !== {MOD_DATA, data_r[ch]})
      $display("FAIL rstmid_data got inc=%b %h want inc=1 %h", bus.fifo_write_inc, bus.fifo_write_data, {MOD_DATA, data_r[ch]});
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.fifo_write_inc !== 1'b0) $display("FAIL rstmid_inc got %b want 0", bus.fifo_write_inc); else n_pass++;
    n_checks++; if (bus.ack !== 4'h0) $display("FAIL rstmid_ack got %h want 0", bus.ack); else n_pass++;
    n_checks++; if (bus.fifo_write_data !== 34'h0) $display("FAIL rstmid_data_zero got %h want 0", bus.fifo_write_data); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", bus.busy); else n_pass++;
    rst = 1'b0;
    m_ptr = N - 1;
    m_lv  = 1'b0;
    model_batch('0, 4'(1 << ch));
    collect(1'b0);
    n_checks++;
    if (log_q.size() !== exp_q.size()) $display("FAIL rstmid_count got %0d want %0d", log_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_q[i]) $display("FAIL rstmid_event[%0d] got %h want %h", i, log_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] pc;
    logic [N-1:0] pd;
    for (int b = 0; b < 25; b++) begin
      log_q.delete(); exp_q.delete();
      rand_regs();
      pc = 4'($urandom);
      pd = 4'($urandom);
      if ((pc | pd) == 0) pd = 4'b0001;
      model_batch(pc, pd);
      bus.req_cfg = pc;
      bus.req_dat = pd;
      collect(1'b1);
      n_checks++;
      if (log_q.size() !== exp_q.size()) $display("FAIL rand_count[%0d] got %0d want %0d", b, log_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
        n_checks++;
        if (log_q[i] !== exp_q[i]) $display("FAIL rand_event[%0d][%0d] got %h want %h", b, i, log_q[i], exp_q[i]); else n_pass++;
      end
    end
  endtask

  initial begin
    bus.req_cfg = '0;
    bus.req_dat = '0;
    bus.fifo_write_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      cfg_r[i] = '0; stat_r[i] = '0; data_r[i] = '0;
    end
    drive_regs();
    test_reset();
    test_first_data();
    test_cfg_same_channel();
    test_rr_order();
    test_backpressure();
    test_snapshot();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
